// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared types and constants for the mnist_nn load path
// Holds the loader FSM encoding, memory target codes and the default
// address/bank-select widths that mnist_nn and its loader must agree on.
package mnist_pkg;

    localparam int W_ADDR_LEN_DEF = 20;
    localparam int X_ADDR_LEN_DEF = 10;
    localparam int W_SEL_LEN_DEF  = 2;
    localparam int X_SEL_LEN_DEF  = 2;
    localparam int BYTE_W_DEF     = 8;
    localparam int CMD_SEL_LEN    = 2;

    localparam logic TARGET_W = 1'b0;
    localparam logic TARGET_X = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_WRITE   = 2'd2,
        ST_COMPUTE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - LSB-first shift register with a bit budget
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load, load_data   capture a new word
//   load_count        number of bits of that word to emit (<= BYTE_W)
//   shift             consume bit_out, move to the next bit
//   bit_out           current bit (LSB of the shift register)
//   last              exactly one bit left in the budget
//   empty             budget exhausted
module bit_serializer #(
    parameter int BYTE_W = 8,
    localparam int CNT_W = $clog2(BYTE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              shift,
    output logic              bit_out,
    output logic              last,
    output logic              empty
);

    logic [BYTE_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= load_count;
        end else if (shift) begin
            sreg <= sreg >> 1;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    assign bit_out = sreg[0];
    assign last    = (cnt == CNT_W'(1));
    assign empty   = (cnt == '0);

endmodule

// File: rtl/mnist_mem_loader.sv
// rtl/mnist_mem_loader.sv - serialising memory loader and compute hand-off for mnist_nn
// Ports:
//   cmd_*        load command: target memory, bank select, first bit address, bit count
//   din_*        byte stream, emitted LSB-first one bit per cycle
//   start        request a compute run (ignored while a command is offered)
//   compute_finish  end of compute from mnist_nn
//   w_*_oc/x_*_oc   one-bit write port towards the weight/activation memories
//   load_compute_ctrl/en_compute  memory ownership and compute enable
//   load_done, compute_done       one-cycle completion pulses
//   busy         FSM not idle
module mnist_mem_loader
    import mnist_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
    parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
    parameter int W_SEL_LEN  = W_SEL_LEN_DEF,
    parameter int X_SEL_LEN  = X_SEL_LEN_DEF,
    parameter int BYTE_W     = BYTE_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_target,
    input  logic [CMD_SEL_LEN-1:0] cmd_sel,
    input  logic [W_ADDR_LEN-1:0]  cmd_base,
    input  logic [W_ADDR_LEN:0]    cmd_len,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [BYTE_W-1:0]      din_data,
    input  logic                   start,
    input  logic                   compute_finish,
    output logic                   load_compute_ctrl,
    output logic                   en_compute,
    output logic                   w_wq_oc,
    output logic                   x_wq_oc,
    output logic [W_ADDR_LEN-1:0]  w_addr_oc,
    output logic [X_ADDR_LEN-1:0]  x_addr_oc,
    output logic                   wx_write_oc,
    output logic [W_SEL_LEN-1:0]   w_sel_oc,
    output logic [X_SEL_LEN-1:0]   x_sel_oc,
    output logic                   load_done,
    output logic                   compute_done,
    output logic                   busy
);

    localparam int CNT_W = $clog2(BYTE_W + 1);
    localparam logic [W_ADDR_LEN:0] REM_ONE = (W_ADDR_LEN + 1)'(1);

    loader_state_t          state;
    logic                   tgt;
    logic [CMD_SEL_LEN-1:0] sel;
    logic [W_ADDR_LEN-1:0]  ptr;
    logic [W_ADDR_LEN:0]    rem;

    logic             ser_load;
    logic             ser_shift;
    logic [CNT_W-1:0] ser_count;
    logic             ser_bit;
    logic             ser_last;
    logic             ser_empty;

    // Bits taken from the next byte: a full byte unless the command ends inside it.
    assign ser_count = (rem >= (W_ADDR_LEN + 1)'(BYTE_W)) ? CNT_W'(BYTE_W) : rem[CNT_W-1:0];
    assign ser_load  = (state == ST_FETCH) && din_valid && din_ready;
    assign ser_shift = (state == ST_WRITE) && (rem != '0) && !ser_empty;

    bit_serializer #(
        .BYTE_W (BYTE_W)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .load_data  (din_data),
        .load_count (ser_count),
        .shift      (ser_shift),
        .bit_out    (ser_bit),
        .last       (ser_last),
        .empty      (ser_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            tgt               <= TARGET_W;
            sel               <= '0;
            ptr               <= '0;
            rem               <= '0;
            cmd_ready         <= 1'b0;
            din_ready         <= 1'b0;
            load_compute_ctrl <= 1'b1;
            en_compute        <= 1'b0;
            w_wq_oc           <= 1'b0;
            x_wq_oc           <= 1'b0;
            w_addr_oc         <= '0;
            x_addr_oc         <= '0;
            wx_write_oc       <= 1'b0;
            w_sel_oc          <= '0;
            x_sel_oc          <= '0;
            load_done         <= 1'b0;
            compute_done      <= 1'b0;
            busy              <= 1'b0;
        end else begin
            load_done    <= 1'b0;
            compute_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    w_wq_oc <= 1'b0;
                    x_wq_oc <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        tgt <= cmd_target;
                        sel <= cmd_sel;
                        ptr <= cmd_base;
                        rem <= cmd_len;
                        if (cmd_len == '0) begin
                            load_done <= 1'b1;
                        end else begin
                            state     <= ST_FETCH;
                            cmd_ready <= 1'b0;
                            din_ready <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end else if (start && !cmd_valid) begin
                        // A pending command always beats start.
                        state             <= ST_COMPUTE;
                        cmd_ready         <= 1'b0;
                        load_compute_ctrl <= 1'b0;
                        en_compute        <= 1'b1;
                        busy              <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    w_wq_oc <= 1'b0;
                    x_wq_oc <= 1'b0;
                    if (din_valid && din_ready) begin
                        din_ready <= 1'b0;
                        state     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (rem == '0) begin
                        // Last bit was presented in the previous cycle.
                        w_wq_oc   <= 1'b0;
                        x_wq_oc   <= 1'b0;
                        load_done <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (ser_empty) begin
                        w_wq_oc   <= 1'b0;
                        x_wq_oc   <= 1'b0;
                        din_ready <= 1'b1;
                        state     <= ST_FETCH;
                    end else begin
                        w_wq_oc     <= (tgt == TARGET_W);
                        x_wq_oc     <= (tgt == TARGET_X);
                        wx_write_oc <= ser_bit;
                        if (tgt == TARGET_W) begin
                            w_addr_oc <= ptr;
                            w_sel_oc  <= W_SEL_LEN'(sel);
                        end else begin
                            x_addr_oc <= ptr[X_ADDR_LEN-1:0];
                            x_sel_oc  <= X_SEL_LEN'(sel);
                        end
                        ptr <= ptr + W_ADDR_LEN'(1);
                        rem <= rem - REM_ONE;
                        // Request the next byte while the last bit of this one is on the bus.
                        if (rem != REM_ONE && ser_last) begin
                            din_ready <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end

                ST_COMPUTE: begin
                    w_wq_oc <= 1'b0;
                    x_wq_oc <= 1'b0;
                    if (compute_finish) begin
                        en_compute        <= 1'b0;
                        load_compute_ctrl <= 1'b1;
                        compute_done      <= 1'b1;
                        cmd_ready         <= 1'b1;
                        busy              <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_mem_loader.sv
// tb/tb_mnist_mem_loader.sv - scoreboard bench for mnist_mem_loader
module tb_mnist_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_target;
    logic [1:0]  cmd_sel;
    logic [19:0] cmd_base;
    logic [20:0] cmd_len;
    logic        din_valid, din_ready;
    logic [7:0]  din_data;
    logic        start, compute_finish;
    logic        load_compute_ctrl, en_compute;
    logic        w_wq_oc, x_wq_oc;
    logic [19:0] w_addr_oc;
    logic [9:0]  x_addr_oc;
    logic        wx_write_oc;
    logic [1:0]  w_sel_oc, x_sel_oc;
    logic        load_done, compute_done, busy;

    mnist_mem_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .start(start), .compute_finish(compute_finish),
        .load_compute_ctrl(load_compute_ctrl), .en_compute(en_compute),
        .w_wq_oc(w_wq_oc), .x_wq_oc(x_wq_oc),
        .w_addr_oc(w_addr_oc), .x_addr_oc(x_addr_oc), .wx_write_oc(wx_write_oc),
        .w_sel_oc(w_sel_oc), .x_sel_oc(x_sel_oc),
        .load_done(load_done), .compute_done(compute_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tgt;
        logic [1:0]  sel;
        logic [19:0] addr;
        logic        data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e, act;
    int  checks = 0, failures = 0;
    int  nwr = 0, done_exp = 0, cdone_exp = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_wq_oc && x_wq_oc) check("both_strobes", 1, 0);
            if (w_wq_oc || x_wq_oc) begin
                nwr++;
                act.tgt  = x_wq_oc;
                act.sel  = x_wq_oc ? x_sel_oc : w_sel_oc;
                act.addr = x_wq_oc ? {10'b0, x_addr_oc} : w_addr_oc;
                act.data = wx_write_oc;
                if (exp_q.size() == 0) check("unexpected_strobe", act, 0);
                else begin
                    e = exp_q.pop_front();
                    check("write{tgt,sel,addr,data}", act, e);
                end
            end
            if (load_done) begin
                if (done_exp == 0) check("unexpected_load_done", 1, 0);
                else begin
                    done_exp--;
                    check("load_done_pending_writes", exp_q.size(), 0);
                end
            end
            if (compute_done) begin
                if (cdone_exp == 0) check("unexpected_compute_done", 1, 0);
                else cdone_exp--;
            end
        end
    end

    task automatic push_wr(input logic t, input logic [1:0] s, input logic [19:0] a, input logic d);
        wr_t w;
        w.tgt = t; w.sel = s; w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic expect_load(input logic t, input logic [1:0] s, input logic [19:0] base,
                               input int len, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0]  bv;
        logic [19:0] a;
        for (int k = 0; k < len; k++) begin
            bv = (k < 8) ? b0 : b1;
            a  = base + 20'(k);
            if (t) a = {10'b0, a[9:0]};
            push_wr(t, s, a, bv[k % 8]);
        end
        done_exp++;
    endtask

    task automatic send_cmd(input logic t, input logic [1:0] s, input logic [19:0] base, input logic [20:0] len);
        bit ok = 0;
        cmd_valid = 1; cmd_target = t; cmd_sel = s; cmd_base = base; cmd_len = len;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) check("cmd_handshake_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok = 0;
        din_valid = 1; din_data = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (din_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) check("din_handshake_timeout", 0, 1);
        @(negedge clk);
        din_valid = 0;
    endtask

    task automatic wait_writes(input int target);
        for (int i = 0; i < 200 && nwr < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("write_count_reached", nwr, target);
    endtask

    task automatic wait_drain();
        @(negedge clk);
        #1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || done_exp != 0); i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_writes", exp_q.size(), 0);
        check("drain_load_done", done_exp, 0);
    endtask

    initial begin
        int n0, bad;
        rst = 1; cmd_valid = 0; cmd_target = 0; cmd_sel = 0; cmd_base = 0; cmd_len = 0;
        din_valid = 0; din_data = 0; start = 0; compute_finish = 0;
        repeat (3) @(negedge clk);
        check("reset_lcc", load_compute_ctrl, 1);
        check("reset_flags", {cmd_ready, din_ready, en_compute, w_wq_oc, x_wq_oc, wx_write_oc,
                              load_done, compute_done, busy}, 0);
        check("reset_buses", {w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc}, 0);
        rst = 0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // Weight write: 0xA5 at 0x10..0x17, sel 2
        expect_load(0, 2'd2, 20'h00010, 8, 8'hA5, 8'h00);
        send_cmd(0, 2'd2, 20'h00010, 21'd8);
        check("fetch_busy_din_ready", {busy, din_ready, cmd_ready}, 3'b110);
        send_byte(8'hA5);
        wait_drain();

        // Activation write with 10-bit wrap and a partial final byte
        expect_load(1, 2'd1, 20'h003FE, 12, 8'hFF, 8'h0C);
        send_cmd(1, 2'd1, 20'h003FE, 21'd12);
        send_byte(8'hFF);
        send_byte(8'h0C);
        wait_drain();

        // Zero-length command
        done_exp++;
        send_cmd(0, 2'd0, 20'h00055, 21'd0);
        check("len0_pulse", {load_done, din_ready, busy}, 3'b100);
        @(negedge clk);
        check("len0_after", {load_done, din_ready, busy}, 3'b000);
        wait_drain();

        // Stream stall of 5 cycles between bytes
        n0 = nwr;
        expect_load(0, 2'd3, 20'h00100, 16, 8'h5A, 8'hC3);
        send_cmd(0, 2'd3, 20'h00100, 21'd16);
        send_byte(8'h5A);
        wait_writes(n0 + 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall_hold{wq,addr,data}", {w_wq_oc, w_addr_oc, wx_write_oc}, {1'b0, 20'h00107, 1'b0});
        end
        send_byte(8'hC3);
        wait_drain();

        // Compute hand-off
        start = 1;
        @(negedge clk);
        start = 0;
        check("compute_entry{lcc,en,busy,cmd_ready}", {load_compute_ctrl, en_compute, busy, cmd_ready}, 4'b0110);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cmd_ready || din_ready || !en_compute || load_compute_ctrl || w_wq_oc || x_wq_oc) bad++;
        end
        check("compute_hold_bad_cycles", bad, 0);
        cdone_exp++;
        compute_finish = 1;
        @(negedge clk);
        compute_finish = 0;
        check("compute_exit{lcc,en,done,busy}", {load_compute_ctrl, en_compute, compute_done, busy}, 4'b1010);
        @(negedge clk);
        check("compute_done_one_cycle", {compute_done, cmd_ready}, 2'b01);
        check("compute_done_seen", cdone_exp, 0);

        // Command and start together: command wins
        done_exp++;
        start = 1;
        send_cmd(0, 2'd0, 20'h00000, 21'd0);
        start = 0;
        check("priority{done,en,lcc,busy}", {load_done, en_compute, load_compute_ctrl, busy}, 4'b1010);
        @(negedge clk);
        check("priority_no_compute", {en_compute, load_compute_ctrl}, 2'b01);
        wait_drain();

        // Reset during the 4th bit; 20-bit address wrap on the way
        n0 = nwr;
        push_wr(0, 2'd1, 20'hFFFFE, 1'b0);
        push_wr(0, 2'd1, 20'hFFFFF, 1'b0);
        push_wr(0, 2'd1, 20'h00000, 1'b1);
        push_wr(0, 2'd1, 20'h00001, 1'b1);
        send_cmd(0, 2'd1, 20'hFFFFE, 21'd16);
        send_byte(8'h3C);
        wait_writes(n0 + 4);
        rst = 1;
        @(negedge clk);
        check("reset_abort{wq_w,wq_x,lcc,busy,done,cmd_ready}",
              {w_wq_oc, x_wq_oc, load_compute_ctrl, busy, load_done, cmd_ready}, 6'b001000);
        rst = 0;
        repeat (20) @(negedge clk);
        #1;
        check("reset_no_more_writes", nwr, n0 + 4);
        check("reset_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mnist_mem_loader.md
Name: mnist_mem_loader

Overview:
Off-chip-side driver for the mnist_nn load/compute interface. It accepts load commands and a byte stream, and serialises each byte LSB-first into one-bit writes on the w_*_oc / x_*_oc ports. It owns load_compute_ctrl and en_compute, so it can hand the memories to the compute engine and take them back once compute_finish rises. In the bench and FPGA wrapper it sits in front of mnist_nn and replaces hand-driven stimulus.

Parameters:
W_ADDR_LEN, 20, weight memory address width
X_ADDR_LEN, 10, activation memory address width
W_SEL_LEN, 2, weight bank select width
X_SEL_LEN, 2, activation bank select width
BYTE_W, 8, input stream word width (bits serialised per byte)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  load command offered
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
cmd_target  in  1  0 = weight memory, 1 = activation memory
cmd_sel  in  2  bank select for this command
cmd_base  in  W_ADDR_LEN  first bit address
cmd_len  in  W_ADDR_LEN+1  number of bits to write
din_valid  in  1  stream byte offered
din_ready  out  1  byte accepted when din_valid and din_ready are both high
din_data  in  BYTE_W  stream byte
start  in  1  request a compute run
compute_finish  in  1  from mnist_nn
load_compute_ctrl  out  1  1 = loader owns the memories
en_compute  out  1  compute enable
w_wq_oc, x_wq_oc  out  1 each  write strobes
w_addr_oc  out  W_ADDR_LEN  weight address
x_addr_oc  out  X_ADDR_LEN  activation address
wx_write_oc  out  1  write data bit
w_sel_oc  out  W_SEL_LEN  weight bank select
x_sel_oc  out  X_SEL_LEN  activation bank select
load_done  out  1  one-cycle pulse at end of a command
compute_done  out  1  one-cycle pulse at end of a compute run
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: load_compute_ctrl=1; every other output 0, including cmd_ready and din_ready. FSM returns to IDLE.
- All outputs are registered.
- FSM states are IDLE, FETCH, WRITE, COMPUTE.
- IDLE:
  - cmd_ready=1.
  - On a cmd handshake, latch target, sel, base and len. Go to FETCH, or if len==0 pulse load_done next cycle and stay in IDLE.
  - If cmd_valid and start are high in the same cycle, the command wins; start must be held to be honoured.
  - start alone goes to COMPUTE.
- FETCH:
  - din_ready=1.
  - On a din handshake, load the shift register, set bitcnt=min(BYTE_W, remaining) and go to WRITE.
- WRITE, one bit per cycle:
  - The selected strobe (w_wq_oc or x_wq_oc) is high for exactly one cycle per bit.
  - During that cycle wx_write_oc = shift[0] and the address equals the current pointer; the sel output holds the latched sel.
  - The non-selected strobe stays 0.
  - After each bit: pointer+1, remaining-1, shift register >>1.
  - When remaining reaches 0: drop the strobe next cycle, pulse load_done, go to IDLE. Unused high bits of the last byte are discarded.
  - When bitcnt is exhausted but remaining>0: go back to FETCH.
- Address arithmetic:
  - The pointer wraps modulo 2^W_ADDR_LEN.
  - For target X, x_addr_oc is the pointer's low X_ADDR_LEN bits, so it wraps at 1024.
  - The unselected address bus holds its last value.
- Throughput: 1 bit/cycle within a byte, plus one FETCH cycle per byte when din_valid is already high.
- COMPUTE:
  - On entry (next cycle): load_compute_ctrl=0, en_compute=1, all write strobes 0.
  - Hold until compute_finish is sampled high. Then en_compute=0, load_compute_ctrl=1, compute_done pulses one cycle, go to IDLE.
  - cmd_ready and din_ready are 0 throughout.
- Reset mid-operation aborts at the next clock edge: any partially serialised byte is lost and all outputs return to reset values.

Decomposition:
- Shared package mnist_pkg holds:
  - FSM state encoding;
  - TARGET_W=0 / TARGET_X=1 constants;
  - default address/sel widths, shared with mnist_nn.
- One natural sub-module, bit_serializer: the shift register plus bitcnt with load/shift/empty, instantiated once.

Test Plan:
- Write test: cmd target=W, sel=2, base=0x00010, len=8; din=0xA5 → w_wq_oc high 8 consecutive cycles at addresses 0x10..0x17 with data 1,0,1,0,0,1,0,1; w_sel_oc=2; x_wq_oc=0; one load_done pulse.
- Partial byte: target=X, base=0x3FE, len=12; din=0xFF then 0x0C → addresses 0x3FE,0x3FF,0x000..0x009 (wrap). The last 4 bits are 0,0,1,1 and the upper nibble of 0x0C is discarded. Exactly 12 strobes.
- len=0 command → no strobes; load_done pulses in the cycle after the handshake; din_ready stays 0.
- Stream stall: din_valid low for 5 cycles between bytes → strobes pause and address/data stay stable; on resume the sequence continues with no missing or duplicate addresses.
- Compute: start in IDLE → load_compute_ctrl=0 and en_compute=1 on the next cycle. compute_finish pulses after 100 cycles → en_compute=0, load_compute_ctrl=1, compute_done for 1 cycle; cmd_ready=0 throughout.
- Priority and reset: cmd_valid and start in the same cycle → command taken, COMPUTE not entered. Asserting rst during the 4th bit of a byte → next cycle all strobes are 0, load_compute_ctrl=1, FSM in IDLE, and no load_done pulse.
